apb_requester_arbiter: RTL and testbench
========================================

APB_REQUESTER_ARBITER -- requirements
Module: apb_requester_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, APB address width.
REQ-003 SHALL have parameter NUM_REQ, default 4, requester count (>=2); IDW = $clog2(NUM_REQ), BPW = DATA_WIDTH/8.
REQ-004 SHALL have one clock and a synchronous, active-high reset: pclk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have preset  in  1  synchronous active-high reset.
REQ-006 SHALL have req_valid  in  NUM_REQ  per-requester request, held until req_ready.
REQ-007 SHALL have req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, slice i = requester i.
REQ-008 SHALL have req_write  in  NUM_REQ  1=write, 0=read.
REQ-009 SHALL have req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
REQ-010 SHALL have req_strb  in  NUM_REQ*BPW  flattened write strobes.
REQ-011 SHALL have req_prot  in  NUM_REQ*3  flattened protection attributes.
REQ-012 SHALL have req_ready  out  NUM_REQ  one-cycle accept pulse.
REQ-013 SHALL have rsp_valid  out  NUM_REQ  one-cycle completion pulse.
REQ-014 SHALL have rsp_rdata  out  DATA_WIDTH  read data of last completion.
REQ-015 SHALL have rsp_error  out  1  pslverr of last completion.
REQ-016 SHALL have grant_id  out  IDW  owner of current/last transfer.
REQ-017 SHALL have paddr  out  ADDR_WIDTH; pprot  out  3; pwrite  out  1; pwdata  out  DATA_WIDTH; pstrb  out  BPW: APB request fields.
REQ-018 SHALL have psel  out  1  and  penable  out  1: APB phase controls (single completer).
REQ-019 SHALL have pready  in  1; prdata  in  DATA_WIDTH; pslverr  in  1: APB completer response.

Function
REQ-020 SHALL use FSM IDLE, SETUP, ACCESS; all outputs registered.
REQ-021 IDLE: if any req_valid at a rising edge, SHALL select the winner, latch its fields into paddr/pprot/pwrite/pwdata/pstrb, set grant_id, enter SETUP; else stay IDLE.
REQ-022 Arbitration SHALL be round-robin: search order last_grant+1, +2, ... modulo NUM_REQ; last_grant updates to winner.
REQ-023 SETUP: psel=1, penable=0, req_ready[grant_id]=1 for exactly this cycle; next state ACCESS unconditionally.
REQ-024 ACCESS: psel=1, penable=1; request fields SHALL stay stable; pready=0 holds ACCESS indefinitely (no timeout).
REQ-025 ACCESS with pready=1: next cycle SHALL be IDLE with psel=0, penable=0, rsp_valid[grant_id]=1 for one cycle, rsp_error=pslverr, rsp_rdata=prdata if read else 0.
REQ-026 rsp_rdata, rsp_error, grant_id SHALL hold until next completion/grant; prdata and pslverr SHALL be ignored unless ACCESS and pready=1.
REQ-027 Latency: req_valid sampled edge N -> SETUP/req_ready cycle N+1 -> ACCESS N+2 -> rsp_valid N+3 minimum; one IDLE cycle separates transfers.
REQ-028 req_valid changes outside IDLE sampling edges SHALL be ignored; a requester deasserting before req_ready SHALL be ignored if not yet granted.
REQ-029 At most one bit of req_ready and of rsp_valid SHALL be set in any cycle.
REQ-030 pwdata and pstrb SHALL be driven with latched values for reads as well (don't-care to completer).

Reset
REQ-031 preset=1 at an edge SHALL force IDLE, psel=penable=0, req_ready=rsp_valid=0, rsp_rdata=0, rsp_error=0, grant_id=0, APB field outputs 0, last_grant=NUM_REQ-1 (requester 0 first).
REQ-032 Reset during SETUP/ACCESS SHALL abort the transfer: no rsp_valid issued, request lost, psel low the cycle after reset.

Verification
REQ-033 Reset 2 cycles, no req -> all outputs 0, psel never asserts.
REQ-034 req0 write addr 122, prot 110, wdata 2772003, strb 1111; pready low 4 ACCESS cycles then pready=1, pslverr=1 -> SETUP 1 cycle, ACCESS 5 cycles, fields stable, rsp_valid[0] pulse, rsp_error=1.
REQ-035 req2 read addr 125, prot 100; pready=1 first ACCESS, prdata=2772003 -> rsp_valid[2] at N+3, rsp_rdata=2772003, rsp_error=0.
REQ-036 req_valid=1111 held continuously, pready=1 -> grant order 0,1,2,3,0, one transfer per 4 cycles.
REQ-037 After grant to 1, req1 and req3 both valid -> next grant 3, then 1.
REQ-038 preset=1 mid-ACCESS with req0 -> psel/penable low next cycle, no rsp_valid, next grant to requester 0.

Source files
------------

// File: rtl/apb_requester_arbiter_if.sv
// Bundles the requester-side and APB-side signals of the requester arbiter.
// master = arbiter view, slave = requesters plus completer view.
interface apb_requester_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BPW = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*BPW-1:0]        req_strb;
  logic [NUM_REQ*3-1:0]          req_prot;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_error;
  logic [IDW-1:0]                grant_id;

  logic [ADDR_WIDTH-1:0]         paddr;
  logic [2:0]                    pprot;
  logic                          pwrite;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [BPW-1:0]                pstrb;
  logic                          psel;
  logic                          penable;
  logic                          pready;
  logic [DATA_WIDTH-1:0]         prdata;
  logic                          pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    input  pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, grant_id,
    output paddr, pprot, pwrite, pwdata, pstrb, psel, penable
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    output pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, grant_id,
    input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable
  );
endinterface

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto one APB completer.
// state  | meaning
// IDLE   | no transfer; samples req_valid unless a completion pulse is out
// SETUP  | psel high, penable low, req_ready pulse to the winner
// ACCESS | psel/penable high, waiting for pready
module apb_requester_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 4
) (
  input  logic                    pclk,
  input  logic                    preset,
  apb_requester_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BPW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q;
  logic [NUM_REQ-1:0]    req_ready_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q;
  logic [IDW-1:0]        grant_id_q;
  logic [IDW-1:0]        last_grant_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            pprot_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [BPW-1:0]        pstrb_q;
  logic                  psel_q;
  logic                  penable_q;

  logic [IDW-1:0]        win_id_d;
  logic [ADDR_WIDTH-1:0] win_addr_d;
  logic [2:0]            win_prot_d;
  logic                  win_write_d;
  logic [DATA_WIDTH-1:0] win_wdata_d;
  logic [BPW-1:0]        win_strb_d;

  // Walk from farthest to nearest offset so the nearest valid requester wins.
  always_comb begin
    win_id_d = last_grant_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        win_id_d = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    win_addr_d  = bus.req_addr[int'(win_id_d)*ADDR_WIDTH +: ADDR_WIDTH];
    win_prot_d  = bus.req_prot[int'(win_id_d)*3 +: 3];
    win_write_d = bus.req_write[win_id_d];
    win_wdata_d = bus.req_wdata[int'(win_id_d)*DATA_WIDTH +: DATA_WIDTH];
    win_strb_d  = bus.req_strb[int'(win_id_d)*BPW +: BPW];
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      paddr_q      <= '0;
      pprot_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          // The completion cycle is part of the finished transfer, not a sampling slot.
          if ((|bus.req_valid) && (rsp_valid_q == '0)) begin
            state_q      <= SETUP;
            grant_id_q   <= win_id_d;
            last_grant_q <= win_id_d;
            req_ready_q  <= NUM_REQ'(1) << win_id_d;
            paddr_q      <= win_addr_d;
            pprot_q      <= win_prot_d;
            pwrite_q     <= win_write_d;
            pwdata_q     <= win_wdata_d;
            pstrb_q      <= win_strb_d;
            psel_q       <= 1'b1;
            penable_q    <= 1'b0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.pready) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
            rsp_error_q <= bus.pslverr;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.paddr     = paddr_q;
  assign bus.pprot     = pprot_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Self-checking bench for apb_requester_arbiter: directed vector table, corner
// sequences, then randomized traffic against a transaction-level model.
module tb_apb_requester_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NR = 4;
  localparam int BW = DW / 8;

  logic pclk;
  logic preset;

  apb_requester_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  apb_requester_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] apb_fields();
    return {14'b0, bus.paddr, bus.pprot, bus.pwrite, bus.pwdata, bus.pstrb};
  endfunction

  task automatic drive_req(input int id, input logic wr, input logic [AW-1:0] a,
                           input logic [2:0] p, input logic [DW-1:0] d, input logic [BW-1:0] s);
    bus.req_write[id]          = wr;
    bus.req_addr[id*AW +: AW]  = a;
    bus.req_prot[id*3 +: 3]    = p;
    bus.req_wdata[id*DW +: DW] = d;
    bus.req_strb[id*BW +: BW]  = s;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    preset = 1'b1;
    repeat (n) @(negedge pclk);
    preset = 1'b0;
  endtask

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] wdata;
    logic [BW-1:0] strb;
    int            waits;
    logic [DW-1:0] prdata;
    logic          err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    int acc;
    logic [63:0] exp_f;
    exp_f = {14'b0, v.addr, v.prot, v.wr, v.wdata, v.strb};
    @(negedge pclk);
    drive_req(v.id, v.wr, v.addr, v.prot, v.wdata, v.strb);
    bus.req_valid = NR'(1) << v.id;
    bus.pready = 1'b0;
    @(negedge pclk);
    check("vec_ready", bus.req_ready, NR'(1) << v.id);
    check("vec_setup_phase", {bus.psel, bus.penable}, 2'b10);
    check("vec_grant_id", bus.grant_id, v.id);
    check("vec_fields", apb_fields(), exp_f);
    bus.req_valid = '0;
    drive_req(v.id, ~v.wr, ~v.addr, ~v.prot, ~v.wdata, ~v.strb);
    // Completer noise during SETUP must be ignored.
    bus.pready  = 1'b1;
    bus.prdata  = 32'hBAD0_BAD0;
    bus.pslverr = ~v.err;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (!(bus.psel && bus.penable)) break;
      acc++;
      check("vec_hold", apb_fields(), exp_f);
      check("vec_no_rsp", bus.rsp_valid, '0);
      bus.pready  = (acc > v.waits);
      bus.prdata  = (acc > v.waits) ? v.prdata : 32'h5A5A_1234;
      bus.pslverr = (acc > v.waits) ? v.err : ~v.err;
    end
    check("vec_access_cycles", acc, v.waits + 1);
    check("vec_rsp_valid", bus.rsp_valid, NR'(1) << v.id);
    check("vec_rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("vec_rsp_error", bus.rsp_error, v.err);
    check("vec_rsp_idle", {bus.psel, bus.penable}, 2'b00);
    bus.pready  = 1'b0;
    bus.prdata  = 32'hFFFF_0000;
    bus.pslverr = ~v.err;
    @(negedge pclk);
    check("vec_rsp_pulse_end", bus.rsp_valid, '0);
    check("vec_rdata_held", {31'b0, bus.rsp_error, bus.rsp_rdata}, {31'b0, v.err, v.exp_rdata});
  endtask

  int g_ids[8];
  int g_cyc[8];
  int g_cnt;

  task automatic collect_grants(input logic [NR-1:0] mask, input bit hold, input int n);
    int cyc;
    g_cnt = 0;
    for (int i = 0; i < 8; i++) begin g_ids[i] = -1; g_cyc[i] = -1; end
    @(negedge pclk);
    bus.pready = 1'b1;
    bus.prdata = '0;
    bus.pslverr = 1'b0;
    bus.req_valid = mask;
    cyc = 0;
    while (cyc < 60 && g_cnt < n) begin
      @(negedge pclk);
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i]) begin
          g_ids[g_cnt] = i;
          g_cyc[g_cnt] = cyc;
          g_cnt++;
          if (!hold) bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.req_valid = '0;
    repeat (5) @(negedge pclk);
  endtask

  function automatic int model_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Randomized-phase model state
  logic          pend[NR];
  logic [AW-1:0] r_addr[NR];
  logic [2:0]    r_prot[NR];
  logic          r_wr[NR];
  logic [DW-1:0] r_wdata[NR];
  logic [BW-1:0] r_strb[NR];

  initial begin
    int exp_order[5];
    bit psel_seen;
    bit bad;
    int last_m, owner, w;
    bit in_flight, exp_grant;
    logic [63:0] g_fields;
    logic g_wr;
    logic [NR-1:0] prev_valid;
    bit prev_eligible, prev_access, prev_pready, prev_err;
    logic [DW-1:0] prev_prdata;
    bit cur_access, cur_eligible;

    vecs[0] = '{0, 1'b1, 10'd122, 3'b110, 32'd2772003, 4'b1111, 4, 32'h1111_2222, 1'b1, 32'd0};
    vecs[1] = '{2, 1'b0, 10'd125, 3'b100, 32'h0000_0000, 4'b0000, 0, 32'd2772003, 1'b0, 32'd2772003};
    vecs[2] = '{3, 1'b1, 10'd1023, 3'b001, 32'hCAFE_F00D, 4'b0101, 1, 32'h7777_7777, 1'b0, 32'd0};
    vecs[3] = '{1, 1'b0, 10'd0, 3'b011, 32'h1234_5678, 4'b1000, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};

    // Reset and quiet idle
    idle_inputs();
    do_reset(2);
    psel_seen = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (bus.psel || bus.penable) psel_seen = 1'b1;
    end
    check("rst_psel_never", psel_seen, 1'b0);
    check("rst_req_ready", bus.req_ready, '0);
    check("rst_rsp_valid", bus.rsp_valid, '0);
    check("rst_rsp_rdata", bus.rsp_rdata, '0);
    check("rst_rsp_error", bus.rsp_error, 1'b0);
    check("rst_grant_id", bus.grant_id, '0);
    check("rst_apb_fields", apb_fields(), '0);

    // All requesters held: strict rotation starting at 0, one transfer per 4 cycles
    exp_order = '{0, 1, 2, 3, 0};
    collect_grants(4'b1111, 1'b1, 5);
    check("rr_count", g_cnt, 5);
    for (int i = 0; i < 5; i++) check("rr_order", g_ids[i], exp_order[i]);
    for (int i = 0; i < 4; i++) check("rr_period", g_cyc[i+1] - g_cyc[i], 4);

    foreach (vecs[i]) run_vec(vecs[i]);

    // After grant to 1, 1 and 3 both pending: 3 first, then 1
    collect_grants(4'b0010, 1'b0, 1);
    check("rr_pre_grant", g_ids[0], 1);
    collect_grants(4'b1010, 1'b0, 2);
    check("rr_skip_first", g_ids[0], 3);
    check("rr_skip_second", g_ids[1], 1);

    // Reset mid-ACCESS aborts the transfer and restores requester-0 priority
    @(negedge pclk);
    drive_req(0, 1'b1, 10'h155, 3'b010, 32'hA5A5_A5A5, 4'b0011);
    bus.pready = 1'b0;
    bus.req_valid = 4'b0001;
    bad = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk);
      if (bus.req_ready[0]) begin bad = 1'b0; break; end
    end
    check("abort_granted", bad, 1'b0);
    bus.req_valid = '0;
    repeat (2) @(negedge pclk);
    check("abort_in_access", {bus.psel, bus.penable}, 2'b11);
    preset = 1'b1;
    bus.pready = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    check("abort_apb_idle", {bus.psel, bus.penable}, 2'b00);
    check("abort_fields_clr", apb_fields(), '0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (bus.rsp_valid != '0 || bus.psel) bad = 1'b1;
    end
    check("abort_no_rsp", bad, 1'b0);
    collect_grants(4'b1111, 1'b0, 1);
    check("abort_next_grant", g_ids[0], 0);

    // Randomized traffic against the transaction model
    idle_inputs();
    do_reset(2);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    last_m = NR - 1;
    owner = 0;
    in_flight = 1'b0;
    g_fields = '0;
    g_wr = 1'b0;
    prev_valid = '0;
    prev_eligible = 1'b1;
    prev_access = 1'b0;
    prev_pready = 1'b0;
    prev_err = 1'b0;
    prev_prdata = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge pclk);
      exp_grant = prev_eligible && (prev_valid != '0);
      check("rnd_ready_onehot", $onehot0(bus.req_ready), 1'b1);
      check("rnd_rsp_onehot", $onehot0(bus.rsp_valid), 1'b1);
      if (exp_grant) begin
        w = model_pick(prev_valid, last_m);
        check("rnd_grant", bus.req_ready, NR'(1) << w);
        check("rnd_grant_id", bus.grant_id, w);
        check("rnd_setup_phase", {bus.psel, bus.penable}, 2'b10);
        g_fields = {14'b0, r_addr[w], r_prot[w], r_wr[w], r_wdata[w], r_strb[w]};
        g_wr = r_wr[w];
        check("rnd_grant_fields", apb_fields(), g_fields);
        last_m = w;
        owner = w;
        in_flight = 1'b1;
        pend[w] = 1'b0;
      end else begin
        check("rnd_no_ready", bus.req_ready, '0);
      end
      if (prev_access && prev_pready) begin
        check("rnd_rsp_valid", bus.rsp_valid, NR'(1) << owner);
        check("rnd_rsp_error", bus.rsp_error, prev_err);
        check("rnd_rsp_rdata", bus.rsp_rdata, g_wr ? '0 : prev_prdata);
        check("rnd_rsp_idle", bus.psel, 1'b0);
        in_flight = 1'b0;
      end else begin
        check("rnd_no_rsp", bus.rsp_valid, '0);
        if (in_flight && !exp_grant) begin
          check("rnd_access_phase", {bus.psel, bus.penable}, 2'b11);
          check("rnd_access_hold", apb_fields(), g_fields);
        end else if (!in_flight) begin
          check("rnd_idle_psel", bus.psel, 1'b0);
        end
      end
      cur_access   = bus.psel && bus.penable;
      cur_eligible = !bus.psel && (bus.rsp_valid == '0);
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && ($urandom % 16 == 0)) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && ($urandom % 4 == 0)) begin
          pend[i]    = 1'b1;
          r_addr[i]  = AW'($urandom);
          r_prot[i]  = 3'($urandom);
          r_wr[i]    = 1'($urandom);
          r_wdata[i] = $urandom;
          r_strb[i]  = BW'($urandom);
          drive_req(i, r_wr[i], r_addr[i], r_prot[i], r_wdata[i], r_strb[i]);
        end
        bus.req_valid[i] = pend[i];
      end
      bus.pready  = ($urandom % 3 != 0);
      bus.prdata  = $urandom;
      bus.pslverr = ($urandom % 4 == 0);
      prev_valid    = bus.req_valid;
      prev_eligible = cur_eligible;
      prev_access   = cur_access;
      prev_pready   = bus.pready;
      prev_prdata   = bus.prdata;
      prev_err      = bus.pslverr;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
